fetch_pc_unit: RTL



---
 rtl/fetch_pc_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register and fetch sequencer (BOOT/RUN/HALT) feeding instruction memory
// Optional macro FETCH_TRACE_EN adds fetch and branch trace counters.
module fetch_pc_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_INSTRUCTIONS = 5,
  parameter int RESET_VECTOR     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Stall,
  input  logic                  i_Branch_Taken,
  input  logic [23:0]           i_Branch_Offset,
  output logic [DATA_WIDTH-1:0] o_Instruction_Address,
  output logic [DATA_WIDTH-1:0] o_PC_Plus_8,
  output logic                  o_Fetch_Valid,
  output logic                  o_Halted
`ifdef FETCH_TRACE_EN
  ,
  output logic [31:0]           o_Fetch_Count,
  output logic [31:0]           o_Branch_Count
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(RESET_VECTOR);
  localparam logic [DATA_WIDTH-1:0] NUM_WORDS = DATA_WIDTH'(NUM_INSTRUCTIONS);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] offset_ext;
  logic [DATA_WIDTH-1:0] branch_target;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  advance;

  // Branch target is relative to the ARM-visible PC (fetch address + 8).
  assign offset_ext    = DATA_WIDTH'($signed(i_Branch_Offset));
  assign branch_target = pc_q + DATA_WIDTH'(8) + {offset_ext[DATA_WIDTH-3:0], 2'b00};
  assign next_pc       = i_Branch_Taken ? branch_target : pc_q + DATA_WIDTH'(4);
  assign advance       = (state_q == ST_RUN) && !i_Stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (advance) begin
          pc_d = next_pc;
          if ((next_pc >> 2) >= NUM_WORDS) state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign o_Instruction_Address = pc_q;
  assign o_PC_Plus_8           = pc_q + DATA_WIDTH'(8);
  assign o_Fetch_Valid         = (state_q == ST_RUN);
  assign o_Halted              = (state_q == ST_HALT);

`ifdef FETCH_TRACE_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (advance) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (i_Branch_Taken) branch_cnt_d = branch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 32'd0;
      branch_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign o_Fetch_Count  = fetch_cnt_q;
  assign o_Branch_Count = branch_cnt_q;
`endif

endmodule
